// File: rtl/conv_run_sequencer.sv
// Run/busy handshake initiator for the conv accelerator: sequences load, run, settle and a
// lockstep output-vs-golden SRAM scan over a programmable number of rounds.
module conv_run_sequencer #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 16,
  parameter int SETTLE_CYCLES  = 10,
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int CYC_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            num_rounds,
  input  logic [ADDR_WIDTH:0]   num_results,
  output logic                  load_req,
  input  logic                  load_ack,
  output logic                  dut_run,
  input  logic                  dut_busy,
  output logic [ADDR_WIDTH-1:0] output_sram_read_address,
  input  logic [DATA_WIDTH-1:0] output_sram_read_data,
  output logic [ADDR_WIDTH-1:0] golden_sram_read_address,
  input  logic [DATA_WIDTH-1:0] golden_sram_read_data,
  output logic [7:0]            round_index,
  output logic                  mismatch_valid,
  output logic [ADDR_WIDTH-1:0] mismatch_addr,
  output logic [DATA_WIDTH-1:0] mismatch_data,
  output logic [ADDR_WIDTH:0]   correct_count,
  output logic [CYC_WIDTH-1:0]  compute_cycles,
  output logic                  round_done,
  output logic                  session_busy,
  output logic                  done,
  output logic                  timeout
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD      = 4'd1;
  localparam logic [3:0] S_WAIT_IDLE = 4'd2;
  localparam logic [3:0] S_RUN       = 4'd3;
  localparam logic [3:0] S_COMPUTE   = 4'd4;
  localparam logic [3:0] S_SETTLE    = 4'd5;
  localparam logic [3:0] S_SCAN      = 4'd6;
  localparam logic [3:0] S_NEXT      = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TO_W-1:0]      TO_LIMIT   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]      TO_ONE     = TO_W'(1);
  localparam logic [ST_W-1:0]      ST_LAST    = ST_W'(SETTLE_CYCLES - 1);
  localparam logic [ST_W-1:0]      ST_ONE     = ST_W'(1);
  localparam logic [ADDR_WIDTH:0]  IDX_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [CYC_WIDTH-1:0] CYC_ONE    = CYC_WIDTH'(1);
  localparam logic [7:0]           ROUND_ONE  = 8'd1;

  logic [3:0]            state_reg;
  logic [7:0]            rounds_reg;
  logic [ADDR_WIDTH:0]   results_reg;
  logic [7:0]            round_index_reg;
  logic                  load_req_reg;
  logic                  dut_run_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH:0]   scan_idx_reg;
  logic                  cmp_valid_reg;
  logic [ADDR_WIDTH-1:0] cmp_addr_reg;
  logic                  mismatch_valid_reg;
  logic [ADDR_WIDTH-1:0] mismatch_addr_reg;
  logic [DATA_WIDTH-1:0] mismatch_data_reg;
  logic [ADDR_WIDTH:0]   correct_count_reg;
  logic [CYC_WIDTH-1:0]  compute_cycles_reg;
  logic [TO_W-1:0]       timeout_count_reg;
  logic [ST_W-1:0]       settle_count_reg;
  logic                  round_done_reg;
  logic                  done_reg;
  logic                  timeout_reg;

  logic [ADDR_WIDTH:0]   scan_inc;
  logic [CYC_WIDTH-1:0]  compute_inc;

  assign scan_inc    = scan_idx_reg + IDX_ONE;
  assign compute_inc = (&compute_cycles_reg) ? compute_cycles_reg : compute_cycles_reg + CYC_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= S_IDLE;
      rounds_reg         <= '0;
      results_reg        <= '0;
      round_index_reg    <= '0;
      load_req_reg       <= 1'b0;
      dut_run_reg        <= 1'b0;
      addr_reg           <= '0;
      scan_idx_reg       <= '0;
      cmp_valid_reg      <= 1'b0;
      cmp_addr_reg       <= '0;
      mismatch_valid_reg <= 1'b0;
      mismatch_addr_reg  <= '0;
      mismatch_data_reg  <= '0;
      correct_count_reg  <= '0;
      compute_cycles_reg <= '0;
      timeout_count_reg  <= '0;
      settle_count_reg   <= '0;
      round_done_reg     <= 1'b0;
      done_reg           <= 1'b0;
      timeout_reg        <= 1'b0;
    end else begin
      round_done_reg     <= 1'b0;
      mismatch_valid_reg <= 1'b0;
      cmp_valid_reg      <= 1'b0;

      // Read data lags the issued address by one cycle; compare against the lagged address.
      if (cmp_valid_reg) begin
        if (output_sram_read_data == golden_sram_read_data) begin
          correct_count_reg <= correct_count_reg + IDX_ONE;
        end else begin
          mismatch_valid_reg <= 1'b1;
          mismatch_addr_reg  <= cmp_addr_reg;
          mismatch_data_reg  <= output_sram_read_data;
        end
      end

      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            rounds_reg         <= num_rounds;
            results_reg        <= num_results;
            done_reg           <= 1'b0;
            timeout_reg        <= 1'b0;
            round_index_reg    <= '0;
            correct_count_reg  <= '0;
            compute_cycles_reg <= '0;
            if (num_rounds == 8'd0) begin
              state_reg <= S_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg    <= S_LOAD;
              load_req_reg <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (load_ack) begin
            load_req_reg <= 1'b0;
            state_reg    <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (!dut_busy) begin
            state_reg          <= S_RUN;
            dut_run_reg        <= 1'b1;
            correct_count_reg  <= '0;
            compute_cycles_reg <= CYC_ONE;
            timeout_count_reg  <= TO_ONE;
          end
        end
        S_RUN, S_COMPUTE: begin
          // Timeout wins over a simultaneous busy drop; the session is abandoned without a scan.
          if (timeout_count_reg == TO_LIMIT) begin
            timeout_reg <= 1'b1;
            done_reg    <= 1'b1;
            dut_run_reg <= 1'b0;
            state_reg   <= S_DONE;
          end else begin
            timeout_count_reg <= timeout_count_reg + TO_ONE;
            if (state_reg == S_RUN) begin
              compute_cycles_reg <= compute_inc;
              if (dut_busy) begin
                dut_run_reg <= 1'b0;
                state_reg   <= S_COMPUTE;
              end
            end else if (dut_busy) begin
              compute_cycles_reg <= compute_inc;
            end else begin
              settle_count_reg <= '0;
              state_reg        <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (settle_count_reg == ST_LAST) begin
            state_reg    <= S_SCAN;
            scan_idx_reg <= '0;
            addr_reg     <= '0;
          end else begin
            settle_count_reg <= settle_count_reg + ST_ONE;
          end
        end
        S_SCAN: begin
          if (scan_idx_reg < results_reg) begin
            cmp_valid_reg <= 1'b1;
            cmp_addr_reg  <= addr_reg;
          end
          if (scan_inc < results_reg) begin
            addr_reg <= scan_inc[ADDR_WIDTH-1:0];
          end
          if (scan_idx_reg == results_reg) begin
            state_reg      <= S_NEXT;
            round_done_reg <= 1'b1;
          end else begin
            scan_idx_reg <= scan_inc;
          end
        end
        S_NEXT: begin
          if (round_index_reg + ROUND_ONE == rounds_reg) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end else begin
            round_index_reg <= round_index_reg + ROUND_ONE;
            load_req_reg    <= 1'b1;
            state_reg       <= S_LOAD;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign load_req                 = load_req_reg;
  assign dut_run                  = dut_run_reg;
  assign output_sram_read_address = addr_reg;
  assign golden_sram_read_address = addr_reg;
  assign round_index              = round_index_reg;
  assign mismatch_valid           = mismatch_valid_reg;
  assign mismatch_addr            = mismatch_addr_reg;
  assign mismatch_data            = mismatch_data_reg;
  assign correct_count            = correct_count_reg;
  assign compute_cycles           = compute_cycles_reg;
  assign round_done               = round_done_reg;
  assign session_busy             = (state_reg != S_IDLE) && (state_reg != S_DONE);
  assign done                     = done_reg;
  assign timeout                  = timeout_reg;

endmodule

// File: tb/tb_conv_run_sequencer.sv
// Directed bench for conv_run_sequencer: table of session vectors plus hand-written timeout,
// ignored-start and mid-scan reset sequences against behavioural loader/accelerator/SRAM models.
module tb_conv_run_sequencer;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    num_rounds = '0;
  logic [AW:0]   num_results = '0;
  logic          load_req;
  logic          load_ack = 1'b0;
  logic          dut_run;
  logic          dut_busy = 1'b0;
  logic [AW-1:0] out_addr, gold_addr;
  logic [DW-1:0] out_rd, gold_rd;
  logic [7:0]    round_index;
  logic          mismatch_valid;
  logic [AW-1:0] mismatch_addr;
  logic [DW-1:0] mismatch_data;
  logic [AW:0]   correct_count;
  logic [31:0]   compute_cycles;
  logic          round_done, session_busy, done, timeout;

  conv_run_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETTLE_CYCLES(10),
                       .TIMEOUT_CYCLES(100), .CYC_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rounds(num_rounds), .num_results(num_results),
    .load_req(load_req), .load_ack(load_ack), .dut_run(dut_run), .dut_busy(dut_busy),
    .output_sram_read_address(out_addr), .output_sram_read_data(out_rd),
    .golden_sram_read_address(gold_addr), .golden_sram_read_data(gold_rd),
    .round_index(round_index), .mismatch_valid(mismatch_valid), .mismatch_addr(mismatch_addr),
    .mismatch_data(mismatch_data), .correct_count(correct_count), .compute_cycles(compute_cycles),
    .round_done(round_done), .session_busy(session_busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] out_mem  [0:(1<<AW)-1];
  logic [DW-1:0] gold_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    out_rd  <= out_mem[out_addr];
    gold_rd <= gold_mem[gold_addr];
  end

  // Accelerator model: busy rises one cycle after run is seen and stays for busy_len cycles.
  int busy_len = 50;
  bit never_busy = 1'b0;
  int busy_rem = 0;
  bit armed = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      dut_busy = 1'b0; busy_rem = 0; armed = 1'b0;
    end else if (busy_rem > 0) begin
      busy_rem--;
      if (busy_rem == 0) dut_busy = 1'b0;
    end else if (armed) begin
      armed = 1'b0; dut_busy = 1'b1; busy_rem = busy_len;
    end else if (dut_run && !never_busy) begin
      armed = 1'b1;
    end
  end

  int ack_delay = 0;
  int ack_wait = 0;
  always @(negedge clk) begin
    if (reset) begin
      load_ack = 1'b0; ack_wait = 0;
    end else if (load_ack) begin
      load_ack = 1'b0;
    end else if (load_req) begin
      if (ack_wait >= ack_delay) begin
        load_ack = 1'b1; ack_wait = 0;
      end else begin
        ack_wait++;
      end
    end
  end

  int rd_cnt = 0, lr_cnt = 0, mm_cnt = 0, run_cycles = 0, addr_err = 0;
  int mm_addr_last = 0, mm_data_last = 0;
  bit lr_prev = 1'b0;
  always @(negedge clk) begin
    if (round_done) rd_cnt++;
    if (load_req && !lr_prev) lr_cnt++;
    lr_prev = load_req;
    if (mismatch_valid) begin
      mm_cnt++; mm_addr_last = int'(mismatch_addr); mm_data_last = int'(mismatch_data);
    end
    if (dut_run) run_cycles++;
    if (out_addr != gold_addr) addr_err++;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_session(input int rounds, input int results, output int lat);
    @(negedge clk);
    start = 1'b1; num_rounds = 8'(rounds); num_results = (AW+1)'(results);
    @(negedge clk);
    start = 1'b0; lat = 0;
    while (!done && lat < 20000) begin
      @(negedge clk);
      lat++;
    end
    chk("done_reached", longint'(done), 1);
  endtask

  typedef struct {
    int rounds; int results; int corrupt; int ack_dly;
    int exp_correct; int exp_cycles; int exp_mm; int exp_rd; int exp_lr; int exp_ridx;
  } vec_t;

  vec_t vecs [7];
  int lat, b_rd, b_lr, b_mm, b_run, cnt;

  initial begin
    vecs[0] = '{0, 72,   -1, 0, 0,    0,  0, 0, 0, 0};
    vecs[1] = '{1, 72,   -1, 0, 72,   52, 0, 1, 1, 0};
    vecs[2] = '{1, 72,    5, 0, 71,   52, 1, 1, 1, 0};
    vecs[3] = '{3, 72,   -1, 7, 72,   52, 0, 3, 3, 2};
    vecs[4] = '{1, 0,    -1, 0, 0,    52, 0, 1, 1, 0};
    vecs[5] = '{2, 1,     0, 3, 0,    52, 2, 2, 2, 1};
    vecs[6] = '{1, 4096, -1, 0, 4096, 52, 0, 1, 1, 0};
    for (int i = 0; i < (1 << AW); i++) begin
      gold_mem[i] = DW'(i * 37 + 5);
      out_mem[i]  = DW'(i * 37 + 5);
    end

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_done", longint'(done), 0);
    chk("rst_session_busy", longint'(session_busy), 0);
    chk("rst_dut_run", longint'(dut_run), 0);
    chk("rst_load_req", longint'(load_req), 0);
    chk("rst_addr", longint'(out_addr), 0);
    chk("rst_correct", longint'(correct_count), 0);
    chk("rst_cycles", longint'(compute_cycles), 0);
    chk("rst_timeout", longint'(timeout), 0);
    chk("rst_round_index", longint'(round_index), 0);

    for (int v = 0; v < 7; v++) begin
      if (vecs[v].corrupt >= 0) begin
        out_mem[vecs[v].corrupt]  = 16'h1234;
        gold_mem[vecs[v].corrupt] = 16'h1235;
      end
      ack_delay = vecs[v].ack_dly;
      b_rd = rd_cnt; b_lr = lr_cnt; b_mm = mm_cnt; b_run = run_cycles;
      run_session(vecs[v].rounds, vecs[v].results, lat);
      if (vecs[v].rounds == 0) chk("zero_round_latency", lat, 0);
      chk("correct_count", longint'(correct_count), vecs[v].exp_correct);
      chk("compute_cycles", longint'(compute_cycles), vecs[v].exp_cycles);
      chk("mismatch_pulses", mm_cnt - b_mm, vecs[v].exp_mm);
      chk("round_done_pulses", rd_cnt - b_rd, vecs[v].exp_rd);
      chk("load_req_pulses", lr_cnt - b_lr, vecs[v].exp_lr);
      chk("round_index", longint'(round_index), vecs[v].exp_ridx);
      chk("timeout_clear", longint'(timeout), 0);
      chk("session_idle", longint'(session_busy), 0);
      chk("run_seen", longint'(run_cycles - b_run > 0), longint'(vecs[v].rounds > 0));
      if (vecs[v].exp_mm > 0) begin
        chk("mismatch_addr", mm_addr_last, vecs[v].corrupt);
        chk("mismatch_data", mm_data_last, 16'h1234);
      end
      if (vecs[v].corrupt >= 0) begin
        out_mem[vecs[v].corrupt]  = DW'(vecs[v].corrupt * 37 + 5);
        gold_mem[vecs[v].corrupt] = DW'(vecs[v].corrupt * 37 + 5);
      end
      $display("vec %0d: rounds=%0d results=%0d correct=%0d cycles=%0d mismatches=%0d round_done=%0d",
               v, vecs[v].rounds, vecs[v].results, correct_count, compute_cycles,
               mm_cnt - b_mm, rd_cnt - b_rd);
    end

    // Timeout: busy never rises; a start during RUN must be ignored.
    never_busy = 1'b1; ack_delay = 0;
    b_rd = rd_cnt; b_lr = lr_cnt; b_run = run_cycles;
    @(negedge clk);
    start = 1'b1; num_rounds = 8'd2; num_results = 13'd8;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!dut_run && cnt < 100) begin @(negedge clk); cnt++; end
    repeat (10) @(negedge clk);
    start = 1'b1; num_rounds = 8'd0;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!timeout && cnt < 1000) begin @(negedge clk); cnt++; end
    chk("timeout_set", longint'(timeout), 1);
    chk("timeout_done", longint'(done), 1);
    chk("timeout_run_low", longint'(dut_run), 0);
    chk("timeout_run_cycles", run_cycles - b_run, 100);
    chk("timeout_round_done", rd_cnt - b_rd, 0);
    chk("timeout_load_req", lr_cnt - b_lr, 1);
    repeat (5) @(negedge clk);
    chk("timeout_run_stays_low", run_cycles - b_run, 100);
    chk("timeout_busy_low", longint'(session_busy), 0);
    $display("timeout: run_cycles=%0d timeout=%0d done=%0d", run_cycles - b_run, timeout, done);
    never_busy = 1'b0;

    run_session(0, 5, lat);
    chk("restart_clears_timeout", longint'(timeout), 0);

    // Reset in the middle of a scan.
    @(negedge clk);
    start = 1'b1; num_rounds = 8'd1; num_results = 13'd72;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (out_addr != 12'd30 && cnt < 1000) begin @(negedge clk); cnt++; end
    chk("scan_reached_30", longint'(out_addr), 30);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_addr", longint'(out_addr), 0);
    chk("midrst_busy", longint'(session_busy), 0);
    chk("midrst_correct", longint'(correct_count), 0);
    chk("midrst_cycles", longint'(compute_cycles), 0);
    chk("midrst_done", longint'(done), 0);
    chk("midrst_mismatch", longint'(mismatch_valid), 0);
    repeat (3) @(negedge clk);
    chk("midrst_no_reads", longint'(out_addr), 0);
    $display("mid-scan reset: addr=%0d busy=%0d", out_addr, session_busy);

    b_rd = rd_cnt;
    run_session(1, 72, lat);
    chk("post_rst_correct", longint'(correct_count), 72);
    chk("post_rst_cycles", longint'(compute_cycles), 52);
    chk("post_rst_round_done", rd_cnt - b_rd, 1);
    chk("addr_lockstep", addr_err, 0);
    $display("post-reset session: correct=%0d cycles=%0d", correct_count, compute_cycles);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
